ps2_controller: RTL and testbench

- PS/2 host-side serial transceiver running on the 50 MHz system clock.
- Deserialises 11-bit device frames (keyboard scan codes) from the open-drain PS2_CLK/PS2_DAT lines and presents each validated byte with a one-cycle strobe.
- Also sends one host command byte on request, using the PS/2 request-to-send protocol.
- Sits under the keyboard interface wrapper, which latches received_data on received_data_en.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_controller_if.sv | 19 +
 rtl/ps2_sync_edge.sv | 26 ++
 rtl/ps2_controller.sv | 160 ++++++++++++++++
 tb/tb_ps2_controller.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and default timing for the PS/2 host transceiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_RTS,
    ST_START,
    ST_TX_BITS,
    ST_TX_STOP,
    ST_WAIT_ACK
  } ps2_state_e;

  localparam int unsigned FRAME_BITS           = 11;
  localparam int unsigned DEF_RTS_CYCLES       = 5000;
  localparam int unsigned DEF_DEV_TIMEOUT      = 750000;
  localparam int unsigned DEF_FRAME_TIMEOUT    = 100000;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_controller_if.sv
// Byte-level command/receive bus between the keyboard wrapper and the PS/2 transceiver.
interface ps2_controller_if;
  logic [7:0] the_command;
  logic       send_command;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       command_was_sent;
  logic       error_communication_timed_out;

  modport master (
    output the_command, send_command,
    input  received_data, received_data_en, command_was_sent, error_communication_timed_out
  );

  modport slave (
    input  the_command, send_command,
    output received_data, received_data_en, command_was_sent, error_communication_timed_out
  );
endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for an asynchronous PS/2 line plus falling-edge detect.
module ps2_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic q,
  output logic fall
);
  logic meta;
  logic prev;

  // Idle PS/2 lines float high, so the chain resets to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta <= 1'b1;
      q    <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      q    <= meta;
      prev <= q;
    end
  end

  assign fall = prev & ~q;
endmodule

// File: rtl/ps2_controller.sv
// PS/2 host transceiver: receives device frames and sends one command byte via request-to-send.
module ps2_controller
  import ps2_pkg::*;
#(
  parameter int unsigned RTS_CYCLES           = DEF_RTS_CYCLES,
  parameter int unsigned DEV_TIMEOUT_CYCLES   = DEF_DEV_TIMEOUT,
  parameter int unsigned FRAME_TIMEOUT_CYCLES = DEF_FRAME_TIMEOUT
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  inout  wire              PS2_CLK,
  inout  wire              PS2_DAT,
  ps2_controller_if.slave  bus
);
  localparam int unsigned TMAX0 = (RTS_CYCLES > DEV_TIMEOUT_CYCLES) ? RTS_CYCLES : DEV_TIMEOUT_CYCLES;
  localparam int unsigned TMAX  = (TMAX0 > FRAME_TIMEOUT_CYCLES) ? TMAX0 : FRAME_TIMEOUT_CYCLES;
  localparam int unsigned TW    = $clog2(TMAX + 1);
  localparam logic [3:0]  LAST_PAYLOAD = 4'(FRAME_BITS - 2);

  ps2_state_e    state;
  logic [TW-1:0] timer;
  logic [3:0]    bit_cnt;
  logic [8:0]    shift;
  logic          clk_oe, dat_oe;
  logic [7:0]    rx_byte;
  logic          rx_en, sent, tmo;

  logic clk_s, clk_fall, dat_s, dat_fall_unused;
  logic frame_expired;

  ps2_sync_edge u_clk_sync (.clk(CLOCK_50), .resetn(resetn), .din(PS2_CLK), .q(clk_s), .fall(clk_fall));
  ps2_sync_edge u_dat_sync (.clk(CLOCK_50), .resetn(resetn), .din(PS2_DAT), .q(dat_s), .fall(dat_fall_unused));

  assign frame_expired = (timer == TW'(FRAME_TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      clk_oe  <= 1'b0;
      dat_oe  <= 1'b0;
      rx_byte <= '0;
      rx_en   <= 1'b0;
      sent    <= 1'b0;
      tmo     <= 1'b0;
    end else begin
      rx_en <= 1'b0;
      sent  <= 1'b0;
      tmo   <= 1'b0;
      case (state)
        ST_IDLE: begin
          timer   <= '0;
          bit_cnt <= '0;
          if (bus.send_command) begin
            shift  <= {odd_parity(bus.the_command), bus.the_command};
            clk_oe <= 1'b1;
            state  <= ST_RTS;
          end else if (clk_fall && !dat_s) begin
            state <= ST_RX;
          end
        end
        // Data and parity shift in from the top; after nine shifts d0 sits in bit 0.
        ST_RX: begin
          if (clk_fall) begin
            timer <= '0;
            if (bit_cnt == LAST_PAYLOAD) begin
              if (dat_s && ^shift) begin
                rx_byte <= shift[7:0];
                rx_en   <= 1'b1;
              end
              state <= ST_IDLE;
            end else begin
              shift   <= {dat_s, shift[8:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (frame_expired) begin
            state <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RTS: begin
          timer <= timer + 1'b1;
          if (timer == TW'(RTS_CYCLES - 2)) dat_oe <= 1'b1;
          if (timer == TW'(RTS_CYCLES - 1)) begin
            clk_oe <= 1'b0;
            timer  <= '0;
            state  <= ST_START;
          end
        end
        ST_START: begin
          if (clk_fall) begin
            dat_oe  <= ~shift[0];
            shift   <= {1'b0, shift[8:1]};
            bit_cnt <= 4'd1;
            timer   <= '0;
            state   <= ST_TX_BITS;
          end else if (timer == TW'(DEV_TIMEOUT_CYCLES - 1)) begin
            tmo    <= 1'b1;
            dat_oe <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_TX_BITS: begin
          if (clk_fall) begin
            timer <= '0;
            if (bit_cnt == LAST_PAYLOAD) begin
              dat_oe <= 1'b0;
              state  <= ST_TX_STOP;
            end else begin
              dat_oe  <= ~shift[0];
              shift   <= {1'b0, shift[8:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (frame_expired) begin
            tmo    <= 1'b1;
            dat_oe <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_TX_STOP: begin
          timer <= timer + 1'b1;
          state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (clk_fall) begin
            if (!dat_s) sent <= 1'b1;
            else        tmo  <= 1'b1;
            timer <= '0;
            state <= ST_IDLE;
          end else if (frame_expired) begin
            tmo   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          clk_oe <= 1'b0;
          dat_oe <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign PS2_CLK = clk_oe ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_oe ? 1'b0 : 1'bz;

  assign bus.received_data                 = rx_byte;
  assign bus.received_data_en              = rx_en;
  assign bus.command_was_sent              = sent;
  assign bus.error_communication_timed_out = tmo;
endmodule

// File: tb/tb_ps2_controller.sv
// Bench for ps2_controller: device-side frame driver, per-cycle strobe/data model, directed sends.
module tb_ps2_controller;
  localparam int RTS  = 5000;
  localparam int DEV  = 2000;
  localparam int FRM  = 200;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  wire  ps2_clk;
  wire  ps2_dat;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

  ps2_controller_if bus ();

  ps2_controller #(
    .RTS_CYCLES(RTS),
    .DEV_TIMEOUT_CYCLES(DEV),
    .FRAME_TIMEOUT_CYCLES(FRM)
  ) dut (
    .CLOCK_50(clk),
    .resetn(resetn),
    .PS2_CLK(ps2_clk),
    .PS2_DAT(ps2_dat),
    .bus(bus)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model state: cycle at which each strobe must appear, and the byte the output must hold.
  int         exp_rx_cyc  = -1;
  int         exp_ack_cyc = -1;
  int         exp_err_cyc = -1;
  logic [7:0] exp_rx_byte = 8'h00;
  logic [7:0] model_rd    = 8'h00;
  bit         chk_en      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, act, req);
    end
  endtask

  function automatic bit frame_ok(input logic [7:0] d, input logic par, input logic stop);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    ones += int'(par);
    return ((ones % 2) == 1) && stop;
  endfunction

  function automatic logic model_parity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return ((ones % 2) == 0);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc == exp_rx_cyc) model_rd = exp_rx_byte;
      check("rx_en",   bus.received_data_en, (cyc == exp_rx_cyc));
      check("rx_data", bus.received_data, model_rd);
      check("cmd_sent", bus.command_was_sent, (cyc == exp_ack_cyc));
      check("timed_out", bus.error_communication_timed_out, (cyc == exp_err_cyc));
    end
  end

  always @(posedge clk) begin
    if (cyc > 90000) begin
      $display("FAIL watchdog: cycle %0d exceeded budget 90000", cyc);
      $fatal(1, "watchdog");
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Device-to-host frame; the 2-flop sync plus registered output puts the strobe 3 cycles after the stop fall.
  task automatic dev_frame(input logic [7:0] d, input logic par, input logic stop, input int nbits);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dev_dat_low = ~f[i];
      wait_n(HALF / 2);
      dev_clk_low = 1'b1;
      if (i == 10 && frame_ok(d, par, stop)) begin
        exp_rx_byte = d;
        exp_rx_cyc  = cyc + 3;
      end
      wait_n(HALF);
      dev_clk_low = 1'b0;
      wait_n(HALF / 2);
    end
    dev_dat_low = 1'b0;
    wait_n(60);
  endtask

  task automatic send_acked(input logic [7:0] c, input logic par_literal);
    int n = 0;
    int lowcnt = 0;
    int datlow = 0;
    logic [9:0] seen = '0;
    bus.the_command  = c;
    bus.send_command = 1'b1;
    wait_n(1);
    bus.send_command = 1'b0;
    while (ps2_clk === 1'b0 && n < RTS + 100) begin
      lowcnt++;
      if (ps2_dat === 1'b0) datlow++;
      wait_n(1);
      n++;
    end
    check("rts_low_cycles", lowcnt, RTS);
    check("rts_dat_low_cycles", datlow, 1);
    check("start_bit", ps2_dat, 1'b0);
    wait_n(HALF);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11) begin
        dev_dat_low = 1'b1;
        wait_n(5);
      end
      dev_clk_low = 1'b1;
      if (i == 11) exp_ack_cyc = cyc + 3;
      wait_n(HALF);
      dev_clk_low = 1'b0;
      if (i <= 10) seen[i-1] = ps2_dat;
      wait_n(HALF);
    end
    dev_dat_low = 1'b0;
    check("tx_data_bits", seen[7:0], c);
    check("tx_parity_model", seen[8], model_parity(c));
    check("tx_parity_literal", seen[8], par_literal);
    check("tx_stop", seen[9], 1'b1);
    wait_n(10);
    check("clk_released_after_send", ps2_clk, 1'b1);
    check("dat_released_after_send", ps2_dat, 1'b1);
  endtask

  task automatic send_silent(input logic [7:0] c);
    bus.the_command  = c;
    bus.send_command = 1'b1;
    exp_err_cyc = cyc + 1 + RTS + DEV;
    wait_n(1);
    bus.send_command = 1'b0;
    wait_n(RTS + DEV + 20);
    check("clk_released_after_timeout", ps2_clk, 1'b1);
    check("dat_released_after_timeout", ps2_dat, 1'b1);
  endtask

  initial begin
    bus.the_command  = 8'h00;
    bus.send_command = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", bus.received_data, 8'h00);
    check("reset_rx_en", bus.received_data_en, 1'b0);
    check("reset_cmd_sent", bus.command_was_sent, 1'b0);
    check("reset_timed_out", bus.error_communication_timed_out, 1'b0);
    check("reset_clk_z", ps2_clk, 1'b1);
    check("reset_dat_z", ps2_dat, 1'b1);
    resetn = 1'b1;
    chk_en = 1'b1;
    wait_n(20);

    dev_frame(8'h75, 1'b0, 1'b1, 11);
    check("rx_75_literal", bus.received_data, 8'h75);
    dev_frame(8'h29, 1'b0, 1'b1, 11);
    check("rx_29_literal", bus.received_data, 8'h29);

    dev_frame(8'h72, 1'b0, 1'b1, 11);
    check("bad_parity_keeps_29", bus.received_data, 8'h29);
    dev_frame(8'h3C, 1'b1, 1'b0, 11);
    check("bad_stop_keeps_29", bus.received_data, 8'h29);

    dev_frame(8'hAA, 1'b0, 1'b1, 4);
    wait_n(2 * FRM);
    dev_frame(8'h6B, 1'b0, 1'b1, 11);
    check("rx_6b_after_abort", bus.received_data, 8'h6B);

    send_acked(8'hFF, 1'b1);
    wait_n(50);

    send_silent(8'hED);
    dev_frame(8'h1C, 1'b0, 1'b1, 11);
    check("rx_1c_after_timeout", bus.received_data, 8'h1C);

    wait_n(20);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
